// File: rtl/z80_uart_pkg.sv
// Shared definitions for the z80_uart serial port: register map, bit indices,
// engine state encodings and oversampling constants.
package z80_uart_defs;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);

  localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] TICK_HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIVL   = 3'd3;
  localparam logic [2:0] REG_DIVH   = 3'd4;

  localparam int unsigned ST_RX_NE   = 0;
  localparam int unsigned ST_TX_NF   = 1;
  localparam int unsigned ST_TX_IDLE = 2;
  localparam int unsigned ST_OE      = 3;
  localparam int unsigned ST_FE      = 4;

  localparam int unsigned CTRL_RXIE = 0;
  localparam int unsigned CTRL_TXIE = 1;
  localparam int unsigned CTRL_LOOP = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/z80_uart_fifo.sv
// Show-ahead synchronous FIFO; push to full and pop of empty are ignored,
// push+pop on a non-empty FIFO keeps occupancy unchanged.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop    = pop & ~empty;
    do_push   = push & (~full | do_pop);
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = CW'(count + CW'(1));
      2'b01:   count_nxt = CW'(count - CW'(1));
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= AW'(wr_ptr + AW'(1));
      if (do_pop)  rd_ptr <= AW'(rd_ptr + AW'(1));
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage is not reset; pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/z80_uart.sv
// Z80-bus 8N1 UART with TX/RX FIFOs and a 16x oversampling baud generator.
// Optional internal loopback (CTRL[2]) is built when Z80_UART_LOOPBACK_EN is defined.
module z80_uart
  import z80_uart_defs::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cs_n,
  input  logic       i_rd_n,
  input  logic       i_wr_n,
  input  logic [2:0] i_addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_en,
  output logic       o_int,
  output logic       o_tx,
  input  logic       i_rx
);

`ifdef Z80_UART_LOOPBACK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic        rd_act, wr_act, rd_prev, wr_prev, rd_edge, wr_edge;
  logic [2:0]  ctrl;
  logic [15:0] div, div_nxt, baud_cnt;
  logic        tick, div_wr;
  logic        oe, fe, oe_set, fe_set, status_rd;
  logic [7:0]  status, rd_mux;

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_rdata;

  tx_state_e         tx_state, tx_state_nxt;
  logic [TICK_W-1:0] tx_tick_cnt, tx_tick_nxt;
  logic [2:0]        tx_bit_cnt, tx_bit_nxt;
  logic [7:0]        tx_shift, tx_shift_nxt;
  logic              tx_line_nxt;

  rx_state_e         rx_state, rx_state_nxt;
  logic [TICK_W-1:0] rx_tick_cnt, rx_tick_nxt;
  logic [2:0]        rx_bit_cnt, rx_bit_nxt;
  logic [7:0]        rx_shift, rx_shift_nxt;
  logic              rx_sync1, rx_sync2, rx_in;

  // Side effects fire only on the first clock of each bus access.
  assign rd_act  = ~i_cs_n & ~i_rd_n;
  assign wr_act  = ~i_cs_n & ~i_wr_n;
  assign rd_edge = rd_act & ~rd_prev;
  assign wr_edge = wr_act & ~wr_prev;

  assign tx_push   = wr_edge & (i_addr == REG_DATA);
  assign rx_pop    = rd_edge & (i_addr == REG_DATA);
  assign status_rd = rd_edge & (i_addr == REG_STATUS);
  assign div_wr    = wr_edge & ((i_addr == REG_DIVL) | (i_addr == REG_DIVH));
  assign tick      = (baud_cnt == 16'd0);

  always_comb begin
    div_nxt = div;
    if (wr_edge && i_addr == REG_DIVL) div_nxt[7:0]  = i_data;
    if (wr_edge && i_addr == REG_DIVH) div_nxt[15:8] = i_data;
  end

  always_comb begin
    status                 = 8'h00;
    status[ST_RX_NE]       = ~rx_empty;
    status[ST_TX_NF]       = ~tx_full;
    status[ST_TX_IDLE]     = tx_empty & (tx_state == TX_IDLE);
    status[ST_OE]          = oe;
    status[ST_FE]          = fe;
    case (i_addr)
      REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_rdata;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = 8'(ctrl);
      REG_DIVL:   rd_mux = div[7:0];
      REG_DIVH:   rd_mux = div[15:8];
      default:    rd_mux = 8'h00;
    endcase
    o_data    = rd_act ? rd_mux : 8'h00;
    o_data_en = rd_act;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_prev  <= 1'b0;
      wr_prev  <= 1'b0;
      ctrl     <= 3'b000;
      div      <= DEFAULT_DIV;
      baud_cnt <= DEFAULT_DIV;
      oe       <= 1'b0;
      fe       <= 1'b0;
      o_int    <= 1'b0;
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
    end else begin
      rd_prev <= rd_act;
      wr_prev <= wr_act;
      if (wr_edge && i_addr == REG_CTRL) ctrl <= i_data[2:0] & CTRL_MASK;
      div <= div_nxt;
      if (div_wr || tick) baud_cnt <= div_nxt;
      else                baud_cnt <= baud_cnt - 16'd1;
      // A new error in the same cycle as a STATUS read wins over the clear.
      oe       <= oe_set | (oe & ~status_rd);
      fe       <= fe_set | (fe & ~status_rd);
      o_int    <= (ctrl[CTRL_RXIE] & ~rx_empty) | (ctrl[CTRL_TXIE] & tx_empty);
      rx_sync1 <= i_rx;
      rx_sync2 <= rx_sync1;
    end
  end

`ifdef Z80_UART_LOOPBACK_EN
  assign rx_in = ctrl[CTRL_LOOP] ? o_tx : rx_sync2;
`else
  assign rx_in = rx_sync2;
`endif

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (tx_push),
    .pop       (tx_pop),
    .wdata     (i_data),
    .rdata     (tx_rdata),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (rx_push),
    .pop       (rx_pop),
    .wdata     (rx_shift),
    .rdata     (rx_rdata),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= 3'd0;
      tx_shift    <= 8'h00;
      o_tx        <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_tick_cnt <= '0;
      rx_bit_cnt  <= 3'd0;
      rx_shift    <= 8'h00;
    end else begin
      tx_state    <= tx_state_nxt;
      tx_tick_cnt <= tx_tick_nxt;
      tx_bit_cnt  <= tx_bit_nxt;
      tx_shift    <= tx_shift_nxt;
      o_tx        <= tx_line_nxt;
      rx_state    <= rx_state_nxt;
      rx_tick_cnt <= rx_tick_nxt;
      rx_bit_cnt  <= rx_bit_nxt;
      rx_shift    <= rx_shift_nxt;
    end
  end

  // TX engine: a frame is launched on a tick; STOP chains straight into the next START.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_tick_nxt  = tx_tick_cnt;
    tx_bit_nxt   = tx_bit_cnt;
    tx_shift_nxt = tx_shift;
    tx_line_nxt  = o_tx;
    tx_pop       = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_nxt = 1'b1;
        if (tick && !tx_empty) begin
          tx_pop       = 1'b1;
          tx_shift_nxt = tx_rdata;
          tx_tick_nxt  = '0;
          tx_line_nxt  = 1'b0;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: if (tick) begin
        tx_tick_nxt = TICK_W'(tx_tick_cnt + TICK_W'(1));
        if (tx_tick_cnt == TICK_LAST) begin
          tx_bit_nxt   = 3'd0;
          tx_line_nxt  = tx_shift[0];
          tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: if (tick) begin
        tx_tick_nxt = TICK_W'(tx_tick_cnt + TICK_W'(1));
        if (tx_tick_cnt == TICK_LAST) begin
          if (tx_bit_cnt == 3'd7) begin
            tx_line_nxt  = 1'b1;
            tx_state_nxt = TX_STOP;
          end else begin
            tx_shift_nxt = {1'b0, tx_shift[7:1]};
            tx_line_nxt  = tx_shift[1];
            tx_bit_nxt   = 3'(tx_bit_cnt + 3'd1);
          end
        end
      end
      TX_STOP: if (tick) begin
        tx_tick_nxt = TICK_W'(tx_tick_cnt + TICK_W'(1));
        if (tx_tick_cnt == TICK_LAST) begin
          if (!tx_empty) begin
            tx_pop       = 1'b1;
            tx_shift_nxt = tx_rdata;
            tx_line_nxt  = 1'b0;
            tx_state_nxt = TX_START;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // RX engine: confirm the start bit at mid-bit, then sample every bit centre.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_tick_nxt  = rx_tick_cnt;
    rx_bit_nxt   = rx_bit_cnt;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    oe_set       = 1'b0;
    fe_set       = 1'b0;
    case (rx_state)
      RX_IDLE: if (tick && !rx_in) begin
        rx_tick_nxt  = '0;
        rx_state_nxt = RX_START;
      end
      RX_START: if (tick) begin
        rx_tick_nxt = TICK_W'(rx_tick_cnt + TICK_W'(1));
        if (rx_tick_cnt == TICK_HALF_LAST) begin
          rx_tick_nxt  = '0;
          rx_bit_nxt   = 3'd0;
          rx_state_nxt = rx_in ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (tick) begin
        rx_tick_nxt = TICK_W'(rx_tick_cnt + TICK_W'(1));
        if (rx_tick_cnt == TICK_LAST) begin
          rx_shift_nxt = {rx_in, rx_shift[7:1]};
          rx_bit_nxt   = 3'(rx_bit_cnt + 3'd1);
          if (rx_bit_cnt == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: if (tick) begin
        rx_tick_nxt = TICK_W'(rx_tick_cnt + TICK_W'(1));
        if (rx_tick_cnt == TICK_LAST) begin
          if (!rx_in)      fe_set  = 1'b1;
          else if (rx_full) oe_set = 1'b1;
          else             rx_push = 1'b1;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_z80_uart.sv
// Scoreboard bench for z80_uart: bus reads and TX frames are checked by monitors
// against queues of hand-computed expectations.
module tb_z80_uart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       data_en;
  logic       irq;
  logic       tx;
  logic       rx = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rd_exp[$];
  logic [7:0] tx_exp[$];

  z80_uart dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_cs_n    (cs_n),
    .i_rd_n    (rd_n),
    .i_wr_n    (wr_n),
    .i_addr    (addr),
    .i_data    (wdata),
    .o_data    (rdata),
    .o_data_en (data_en),
    .o_int     (irq),
    .o_tx      (tx),
    .i_rx      (rx)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endfunction

  function automatic void fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endfunction

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] exp);
    rd_exp.push_back(exp);
    @(posedge clk); #1;
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (16) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Read monitor: compares o_data on the first sampled cycle of every read access.
  initial begin : rd_mon
    logic en_q;
    logic [7:0] e;
    en_q = 1'b0;
    forever begin
      @(negedge clk);
      if (data_en && !en_q) begin
        if (rd_exp.size() == 0) begin
          fail_now("rd_unexpected", $sformatf("got %02h, expected no read", rdata));
        end else begin
          e = rd_exp.pop_front();
          check($sformatf("rd_addr%0d", addr), 32'(rdata), 32'(e));
        end
      end
      en_q = data_en;
    end
  end

  // TX monitor: every frame must hold each of its 10 bit levels for exactly 16 clocks.
  initial begin : tx_mon
    logic [9:0]  frame;
    logic [15:0] samp;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        if (tx_exp.size() == 0) begin
          fail_now("tx_unexpected_start", "got start bit, expected idle line");
          b = 8'h00;
        end else begin
          b = tx_exp.pop_front();
        end
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
          for (int s = 0; s < 16; s++) begin
            if (i != 0 || s != 0) @(negedge clk);
            samp[s] = tx;
          end
          check($sformatf("tx_%02h_bit%0d", b, i), 32'(samp), frame[i] ? 32'h0000_FFFF : 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] oe_bytes[$];
    int drain;

    idle(3);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_int", 32'(irq), 32'd0);
    check("reset_data", 32'(rdata), 32'd0);
    check("reset_data_en", 32'(data_en), 32'd0);
    rst_n = 1'b1;
    idle(2);
    bus_read(3'd1, 8'h06);

    // Single TX frame, then idle reported again.
    tx_exp.push_back(8'hA5);
    bus_write(3'd0, 8'hA5);
    bus_read(3'd1, 8'h02);
    idle(170);
    bus_read(3'd1, 8'h06);

    // Back-to-back frames.
    tx_exp.push_back(8'h01);
    tx_exp.push_back(8'h80);
    bus_write(3'd0, 8'h01);
    bus_write(3'd0, 8'h80);
    idle(340);
    bus_read(3'd1, 8'h06);

    // RX with RXIE.
    bus_write(3'd2, 8'h01);
    idle(2);
    check("int_rx_before", 32'(irq), 32'd0);
    send_rx(8'h3C, 1'b1);
    idle(2);
    check("int_rx_after", 32'(irq), 32'd1);
    bus_read(3'd0, 8'h3C);
    idle(2);
    check("int_rx_cleared", 32'(irq), 32'd0);
    bus_read(3'd0, 8'h00);

    // Framing error: low stop bit.
    send_rx(8'h81, 1'b0);
    idle(8);
    bus_read(3'd1, 8'h16);
    bus_read(3'd1, 8'h06);

    // Overrun: one frame more than the FIFO holds.
    for (int k = 0; k < 17; k++) begin
      oe_bytes.push_back(8'(k * 7 + 3));
      send_rx(8'(k * 7 + 3), 1'b1);
    end
    idle(4);
    check("int_rx_full", 32'(irq), 32'd1);
    bus_read(3'd1, 8'h0F);
    bus_read(3'd1, 8'h07);
    for (int k = 0; k < 16; k++) bus_read(3'd0, oe_bytes[k]);
    bus_read(3'd0, 8'h00);
    bus_read(3'd1, 8'h06);

    // TX-empty interrupt.
    bus_write(3'd2, 8'h02);
    idle(2);
    check("int_tx_empty", 32'(irq), 32'd1);
    bus_write(3'd2, 8'h00);
    idle(2);
    check("int_off", 32'(irq), 32'd0);

    // Divisor readback, unmapped registers.
    bus_write(3'd3, 8'h34);
    bus_write(3'd4, 8'h12);
    bus_read(3'd3, 8'h34);
    bus_read(3'd4, 8'h12);
    bus_write(3'd3, 8'h00);
    bus_write(3'd4, 8'h00);
    bus_write(3'd5, 8'hFF);
    bus_read(3'd5, 8'h00);
    bus_read(3'd7, 8'h00);

    // CTRL loop bit.
    bus_write(3'd2, 8'h05);
`ifdef Z80_UART_LOOPBACK_EN
    bus_read(3'd2, 8'h05);
    tx_exp.push_back(8'h5A);
    bus_write(3'd0, 8'h5A);
    idle(200);
    check("int_loopback", 32'(irq), 32'd1);
    bus_read(3'd0, 8'h5A);
`else
    bus_read(3'd2, 8'h01);
`endif

    drain = 0;
    while ((tx_exp.size() != 0 || rd_exp.size() != 0) && drain < 2000) begin
      @(posedge clk);
      drain++;
    end
    if (tx_exp.size() != 0 || rd_exp.size() != 0)
      fail_now("drain", $sformatf("got %0d tx / %0d rd pending, expected 0", tx_exp.size(), rd_exp.size()));
    idle(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
